// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_load_ctrl
//  Description : Streams host words into the byte-wide instruction memory as
//                big-endian byte writes, holding the CPU stalled while loading.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_load_ctrl #(
    parameter int WORD_LEN       = 32,
    parameter int MEM_CELL_SIZE  = 8,
    parameter int INSTR_MEM_SIZE = 1024,
    parameter int CNT_W          = 16,
    parameter int ADDR_W         = $clog2(INSTR_MEM_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [ADDR_W-1:0]        load_base,
    input  logic [CNT_W-1:0]         load_count,
    input  logic                     abort,
    input  logic                     in_valid,
    input  logic [WORD_LEN-1:0]      in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [MEM_CELL_SIZE-1:0] mem_wdata,
    output logic                     cpu_stall,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [CNT_W-1:0]         words_written
);

    localparam int c_BYTES  = WORD_LEN / MEM_CELL_SIZE;
    localparam int c_BIDX_W = $clog2(c_BYTES);
    localparam int c_EXT_W  = CNT_W + ADDR_W + 2;

    localparam logic [c_BIDX_W-1:0] c_LAST_BYTE = c_BIDX_W'(c_BYTES - 1);
    localparam logic [c_EXT_W-1:0]  c_MEM_SIZE  = c_EXT_W'(INSTR_MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_W-1:0]     r_ptr;
    logic [CNT_W-1:0]      r_remaining;
    logic [CNT_W-1:0]      r_words;
    logic [WORD_LEN-1:0]   r_shift;
    logic [c_BIDX_W-1:0]   r_byte;
    logic                  r_done_imm;
    logic                  r_err;

    logic                  w_start_ok;
    logic                  w_start_zero;
    logic                  w_start_bad;
    logic                  w_accept;
    logic                  w_byte_wr;
    logic                  w_word_done;
    logic                  w_abort;
    logic                  w_misaligned;
    logic                  w_oob;
    logic [c_EXT_W-1:0]    w_end_addr;

    // End address is computed wide enough that a huge count can never wrap
    // back into range.
    assign w_end_addr   = c_EXT_W'(load_base) + (c_EXT_W'(load_count) << c_BIDX_W);
    assign w_oob        = (w_end_addr > c_MEM_SIZE);
    assign w_misaligned = (load_base[c_BIDX_W-1:0] != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_ok   = 1'b0;
        w_start_zero = 1'b0;
        w_start_bad  = 1'b0;
        w_accept     = 1'b0;
        w_byte_wr    = 1'b0;
        w_word_done  = 1'b0;
        w_abort      = 1'b0;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        busy         = 1'b0;
        cpu_stall    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    if (load_count == '0) begin
                        w_start_zero = 1'b1;
                    end else if (w_misaligned || w_oob) begin
                        w_start_bad = 1'b1;
                    end else begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                in_ready  = 1'b1;
                busy      = 1'b1;
                cpu_stall = 1'b1;
                if (abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                mem_we    = 1'b1;
                busy      = 1'b1;
                cpu_stall = 1'b1;
                if (abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_byte_wr = 1'b1;
                    if (r_byte == c_LAST_BYTE) begin
                        w_word_done = 1'b1;
                        w_state_nxt = (r_remaining == CNT_W'(1)) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                cpu_stall   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: pointer, word shifter and bookkeeping counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_words     <= '0;
            r_shift     <= '0;
            r_byte      <= '0;
            r_done_imm  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done_imm <= w_start_zero;
            r_err      <= w_start_bad | w_abort;

            if (w_start_ok) begin
                r_ptr       <= load_base;
                r_remaining <= load_count;
                r_words     <= '0;
            end

            if (w_accept) begin
                r_shift <= in_data;
                r_byte  <= '0;
            end

            if (w_byte_wr) begin
                r_ptr   <= r_ptr + ADDR_W'(1);
                r_shift <= r_shift << MEM_CELL_SIZE;
                r_byte  <= r_byte + c_BIDX_W'(1);
            end

            if (w_word_done) begin
                r_words     <= r_words + CNT_W'(1);
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    // Address/data are forced to zero outside WR so the memory bus idles clean.
    assign mem_addr      = (r_state == S_WR) ? r_ptr : '0;
    assign mem_wdata     = (r_state == S_WR) ? r_shift[WORD_LEN-1 -: MEM_CELL_SIZE] : '0;
    assign done          = r_done_imm | (r_state == S_DONE);
    assign err           = r_err;
    assign words_written = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_load_ctrl
//  Description : Directed self-checking bench for imem_load_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_load_ctrl;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [9:0]  load_base;
    logic [15:0] load_count;
    logic        abort;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_stall;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_written;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [9:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    logic [7:0] mem_model [0:1023];

    imem_load_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .load_base     (load_base),
        .load_count    (load_count),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_stall     (cpu_stall),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: records every byte written on a rising edge.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            mem_model[mem_addr] = mem_wdata;
        end
    end

    task automatic start_load(input logic [9:0] base, input logic [15:0] cnt);
        load_start = 1'b1;
        load_base  = base;
        load_count = cnt;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL send_word_timeout in_ready=%b want 1", in_ready);
        else pass_cnt++;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        load_start = 1'b1;
        load_base  = 10'h010;
        load_count = 16'd3;
        abort      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({mem_we, in_ready, busy, cpu_stall, done, err} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000", {mem_we, in_ready, busy, cpu_stall, done, err});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata, words_written} !== 34'b0)
            $display("FAIL reset_buses addr=%h data=%h ww=%0d want 0", mem_addr, mem_wdata, words_written);
        else pass_cnt++;
        load_start = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || wr_addr_q.size() != 0)
            $display("FAIL reset_release busy=%b writes=%0d want 0/0", busy, wr_addr_q.size());
        else pass_cnt++;
    endtask

    task automatic test_basic_load();
        logic [9:0] exp_a [0:7];
        logic [7:0] exp_d [0:7];
        bit ok;
        exp_a = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016, 10'h017};
        exp_d = '{8'h80, 8'h20, 8'h00, 8'h06, 8'h80, 8'h40, 8'h00, 8'h01};
        wr_addr_q.delete();
        wr_data_q.delete();
        start_load(10'h010, 16'd2);
        total_cnt++;
        if ({busy, cpu_stall, in_ready} !== 3'b111)
            $display("FAIL basic_wait busy/stall/ready=%b want 111", {busy, cpu_stall, in_ready});
        else pass_cnt++;
        send_word(32'h8020_0006);
        send_word(32'h8040_0001);
        wait_done(ok);
        total_cnt++;
        if (!ok || cpu_stall !== 1'b1)
            $display("FAIL basic_done done_seen=%0d stall=%b want 1/1", ok, cpu_stall);
        else pass_cnt++;
        total_cnt++;
        if (words_written !== 16'd2) $display("FAIL basic_words got %0d want 2", words_written);
        else pass_cnt++;
        total_cnt++;
        if (wr_addr_q.size() != 8) $display("FAIL basic_nwrites got %0d want 8", wr_addr_q.size());
        else pass_cnt++;
        for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
            total_cnt++;
            if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i])
                $display("FAIL basic_byte%0d got %h:%h want %h:%h", i, wr_addr_q[i], wr_data_q[i], exp_a[i], exp_d[i]);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({done, busy, cpu_stall} !== 3'b000)
            $display("FAIL basic_after_done done/busy/stall=%b want 000", {done, busy, cpu_stall});
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [0:7];
        bit ok;
        bit bad;
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        start_load(10'h040, 16'd2);
        send_word(32'h1122_3344);
        while (in_ready !== 1'b1 && total_cnt < 100000) @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (in_ready !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (bad) $display("FAIL bp_hold stall cycles not WAIT-like got bad=1 want 0");
        else pass_cnt++;
        send_word(32'hAABB_CCDD);
        wait_done(ok);
        total_cnt++;
        if (!ok) $display("FAIL bp_done done_seen=0 want 1");
        else pass_cnt++;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) if (mem_model[10'h040 + i] !== exp_d[i]) bad = 1'b1;
        total_cnt++;
        if (bad) $display("FAIL bp_data mem[040]=%h mem[047]=%h want 11/dd", mem_model[10'h040], mem_model[10'h047]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_bounds();
        int n0;
        bit ok;
        n0 = wr_addr_q.size();
        start_load(10'h020, 16'd0);
        total_cnt++;
        if ({done, err, busy} !== 3'b100)
            $display("FAIL bounds_zero done/err/busy=%b want 100", {done, err, busy});
        else pass_cnt++;
        total_cnt++;
        if (words_written !== 16'd2) $display("FAIL bounds_zero_ww got %0d want 2", words_written);
        else pass_cnt++;
        @(negedge clk);
        start_load(10'h3FE, 16'd1);
        total_cnt++;
        if ({done, err, busy} !== 3'b010)
            $display("FAIL bounds_misalign done/err/busy=%b want 010", {done, err, busy});
        else pass_cnt++;
        @(negedge clk);
        start_load(10'h3F8, 16'd3);
        total_cnt++;
        if ({done, err, busy} !== 3'b010)
            $display("FAIL bounds_oob done/err/busy=%b want 010", {done, err, busy});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (wr_addr_q.size() != n0) $display("FAIL bounds_nowrite got %0d want %0d", wr_addr_q.size(), n0);
        else pass_cnt++;
        start_load(10'h3FC, 16'd1);
        send_word(32'hDEAD_BEEF);
        wait_done(ok);
        total_cnt++;
        if (!ok || wr_addr_q.size() != n0 + 4)
            $display("FAIL bounds_top done_seen=%0d writes=%0d want 1/%0d", ok, wr_addr_q.size(), n0 + 4);
        else pass_cnt++;
        total_cnt++;
        if ({mem_model[10'h3FC], mem_model[10'h3FD], mem_model[10'h3FE], mem_model[10'h3FF]} !== 32'hDEAD_BEEF)
            $display("FAIL bounds_top_data got %h%h%h%h want deadbeef", mem_model[10'h3FC], mem_model[10'h3FD],
                     mem_model[10'h3FE], mem_model[10'h3FF]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int n0;
        n0 = wr_addr_q.size();
        start_load(10'h080, 16'd2);
        send_word(32'hCAFE_F00D);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total_cnt++;
        if ({mem_we, err, busy} !== 3'b010)
            $display("FAIL abort_state we/err/busy=%b want 010", {mem_we, err, busy});
        else pass_cnt++;
        total_cnt++;
        if (words_written !== 16'd0) $display("FAIL abort_words got %0d want 0", words_written);
        else pass_cnt++;
        total_cnt++;
        if (wr_addr_q.size() != n0 + 2 || mem_model[10'h080] !== 8'hCA || mem_model[10'h081] !== 8'hFE)
            $display("FAIL abort_bytes writes=%0d m80=%h m81=%h want %0d/ca/fe", wr_addr_q.size() - n0,
                     mem_model[10'h080], mem_model[10'h081], 2);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (err !== 1'b0) $display("FAIL abort_err_pulse got %b want 0", err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        start_load(10'h100, 16'd2);
        send_word(32'h5566_7788);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({mem_we, busy, cpu_stall} !== 3'b000)
            $display("FAIL rstmid_async we/busy/stall=%b want 000", {mem_we, busy, cpu_stall});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_load(10'h000, 16'd1);
        send_word(32'h0102_0304);
        wait_done(ok);
        total_cnt++;
        if (!ok || words_written !== 16'd1)
            $display("FAIL rstmid_reload done_seen=%0d ww=%0d want 1/1", ok, words_written);
        else pass_cnt++;
        total_cnt++;
        if ({mem_model[0], mem_model[1], mem_model[2], mem_model[3]} !== 32'h0102_0304)
            $display("FAIL rstmid_data got %h%h%h%h want 01020304", mem_model[0], mem_model[1], mem_model[2],
                     mem_model[3]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_model[i] = 8'h00;
        test_reset();
        test_basic_load();
        test_backpressure();
        test_bounds();
        test_abort();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1);
    end

endmodule
`default_nettype wire
